// File: rtl/key_report_framer.sv
// key_report_framer: queues key/LR events and frames each one as a 6-byte report.
// Ports: clk_sys/rst (async, active-high); key_instruct_valid/key_instruct and
// key_status_valid/key_lr_status event inputs; tx_data/tx_valid/tx_ready byte
// stream; fifo_overflow drop pulse; drop_cnt saturating drop counter.
module key_report_framer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HEAD0      = 8'hEB,
  parameter logic [7:0] HEAD1      = 8'h90,
  parameter logic [7:0] TYPE_KEY   = 8'h01,
  parameter logic [7:0] TYPE_LR    = 8'h02
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        key_instruct_valid,
  input  logic [15:0] key_instruct,
  input  logic        key_status_valid,
  input  logic        key_lr_status,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fifo_overflow,
  output logic [15:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      r_state, w_state_nxt;
  logic [16:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_pend_v, r_pend_d;
  logic [16:0] r_frame;
  logic [2:0]  r_idx, w_idx_nxt;
  logic        r_ovf;
  logic [15:0] r_drop;
  logic        w_empty, w_full, w_wr, w_pop, w_drop;
  logic [16:0] w_wdata;
  logic [7:0]  w_type, w_chk;
  assign w_empty = r_wptr == r_rptr;
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // Write source priority: key strobe, then the deferred L/R event, then a fresh L/R strobe.
  assign w_wr    = key_instruct_valid | r_pend_v | key_status_valid;
  assign w_wdata = key_instruct_valid ? {1'b0, key_instruct}
                                      : {1'b1, 15'b0, r_pend_v ? r_pend_d : key_lr_status};
  // Fullness is judged at the start of the cycle, so a same-cycle pop cannot save a write.
  assign w_drop  = w_wr & w_full;
  assign w_pop   = (r_state == IDLE) & ~w_empty;
  assign w_type  = r_frame[16] ? TYPE_LR : TYPE_KEY;
  assign w_chk   = w_type + r_frame[15:8] + r_frame[7:0];
  assign tx_valid = r_state == SEND;
  assign tx_data  = !tx_valid    ? 8'h00 :
                    r_idx == 3'd0 ? HEAD0 :
                    r_idx == 3'd1 ? HEAD1 :
                    r_idx == 3'd2 ? w_type :
                    r_idx == 3'd3 ? r_frame[15:8] :
                    r_idx == 3'd4 ? r_frame[7:0] : w_chk;
  assign fifo_overflow = r_ovf;
  assign drop_cnt      = r_drop;
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == IDLE) begin
      w_idx_nxt = 3'd0;
      if (!w_empty) w_state_nxt = SEND;
    end else if (tx_ready) begin
      w_idx_nxt = r_idx + 3'd1;
      if (r_idx == 3'd5) w_state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_pend_v <= 1'b0;
      r_pend_d <= 1'b0;
      r_frame  <= '0;
      r_idx    <= '0;
      r_state  <= IDLE;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_wr && !w_full) begin
        r_mem[r_wptr[AW-1:0]] <= w_wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_frame <= r_mem[r_rptr[AW-1:0]];
        r_rptr  <= r_rptr + 1'b1;
      end
      // A key strobe defers any L/R event; otherwise the pending slot drains and only
      // refills if a new L/R strobe arrives in the same cycle it drains.
      r_pend_v <= key_instruct_valid ? (key_status_valid | r_pend_v) : (r_pend_v & key_status_valid);
      r_pend_d <= key_status_valid ? key_lr_status : r_pend_d;
      r_ovf    <= w_drop;
      r_drop   <= (w_drop && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
    end
  end
endmodule

// File: tb/tb_key_report_framer.sv
// tb_key_report_framer: randomized and directed scoreboard bench for key_report_framer.
module tb_key_report_framer;
  localparam int DEPTH = 8;
  logic        clk_sys = 0, rst = 1;
  logic        key_instruct_valid = 0, key_status_valid = 0, key_lr_status = 0, tx_ready = 0;
  logic [15:0] key_instruct = 0;
  logic [7:0]  tx_data;
  logic        tx_valid, fifo_overflow;
  logic [15:0] drop_cnt;
  int          n_cmp = 0, n_bad = 0, ovf_cnt = 0;
  logic [16:0] mq[$];
  logic [7:0]  exp_q[$], got[$];
  int          m_pend = -1, m_rem = 0, m_drops = 0;
  bit          m_busy = 0, m_ovf = 0, prev_stall = 0;
  logic [7:0]  prev_data = 0;

  key_report_framer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .key_instruct_valid(key_instruct_valid), .key_instruct(key_instruct),
    .key_status_valid(key_status_valid), .key_lr_status(key_lr_status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_overflow(fifo_overflow), .drop_cnt(drop_cnt));

  always #5 clk_sys = ~clk_sys;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fb(input logic [16:0] e, input int i);
    logic [7:0] t;
    t = e[16] ? 8'h02 : 8'h01;
    case (i)
      0: return 8'hEB;
      1: return 8'h90;
      2: return t;
      3: return e[15:8];
      4: return e[7:0];
      default: return 8'(t + e[15:8] + e[7:0]);
    endcase
  endfunction

  // Frame-level reference: event queue, one pending L/R slot, one frame in flight.
  always @(posedge clk_sys or posedge rst) begin
    bit full, has_w, pop;
    logic [16:0] w, e;
    if (rst) begin
      mq.delete(); exp_q.delete();
      m_pend = -1; m_busy = 0; m_rem = 0; m_ovf = 0; m_drops = 0;
    end else begin
      full = mq.size() == DEPTH;
      has_w = 1;
      w = '0;
      if (key_instruct_valid) begin
        w = {1'b0, key_instruct};
        if (key_status_valid) m_pend = int'(key_lr_status);
      end else if (m_pend >= 0) begin
        w = {1'b1, 15'b0, m_pend[0]};
        m_pend = key_status_valid ? int'(key_lr_status) : -1;
      end else if (key_status_valid) w = {1'b1, 15'b0, key_lr_status};
      else has_w = 0;
      pop = !m_busy && mq.size() > 0;
      if (m_busy && tx_ready) begin
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end
      if (pop) begin
        e = mq.pop_front();
        for (int i = 0; i < 6; i++) exp_q.push_back(fb(e, i));
        m_busy = 1;
        m_rem = 6;
      end
      m_ovf = has_w && full;
      if (has_w) begin
        if (full) m_drops = m_drops < 65535 ? m_drops + 1 : m_drops;
        else mq.push_back(w);
      end
    end
  end

  always @(negedge clk_sys) begin
    if (rst) prev_stall = 0;
    else begin
      chk("tx_valid", 64'(tx_valid), 64'(m_busy));
      chk("fifo_overflow", 64'(fifo_overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      if (fifo_overflow) ovf_cnt++;
      if (prev_stall) chk("hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 64'(tx_data), 64'hDEAD);
        else chk("byte", 64'(tx_data), 64'(exp_q.pop_front()));
        got.push_back(tx_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic cyc(input bit kv, input logic [15:0] k, input bit sv, input bit s, input bit r);
    @(posedge clk_sys); #1;
    key_instruct_valid = kv; key_instruct = k; key_status_valid = sv; key_lr_status = s; tx_ready = r;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, r);
  endtask

  task automatic chk_frame(input string nm, input logic [47:0] exp);
    logic [47:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[39:0], got.size() > 0 ? got.pop_front() : 8'h00};
    chk(nm, 64'(v), 64'(exp));
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_outputs", {39'd0, tx_valid, fifo_overflow, tx_data, drop_cnt}, 64'd0);
    rst = 0;
    idle(2, 1);
    cyc(1, 16'h1234, 0, 0, 1); idle(12, 1);
    chk_frame("key_1234", 48'hEB9001123447);
    cyc(0, 0, 1, 1, 1); idle(12, 1);
    chk_frame("lr_1", 48'hEB9002000103);
    cyc(1, 16'hFFFF, 0, 0, 1); idle(12, 1);
    chk_frame("key_ffff_wrap", 48'hEB9001FFFFFF);
    cyc(1, 16'h00A5, 1, 0, 1); idle(20, 1);
    chk_frame("simul_key", 48'hEB900100A5A6);
    chk_frame("simul_lr", 48'hEB9002000002);
    cyc(1, 16'hBEEF, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, i[0]);
    chk_frame("backpressure", 48'hEB9001BEEFAE);
    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) cyc(1, 16'(i), 0, 0, 0);
    idle(3, 0);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_pulses", 64'(ovf_cnt), 64'd1);
    idle(90, 1);
    chk("ovf_frames", 64'(got.size()), 64'd54);
    for (int i = 0; i < 9; i++)
      chk_frame("ovf_order", {8'hEB, 8'h90, 8'h01, 16'(i), 8'(8'h01 + i)});
    got.delete();
    for (int i = 0; i < 4; i++) cyc(1, 16'h0100 + 16'(i), 0, 0, 0);
    idle(4, 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk_sys); #1;
      if (got.size() >= 3) begin hit = 1; tx_ready = 0; end
      else tx_ready = 1;
    end
    chk("reach_byte3", 64'(hit), 64'd1);
    #2 rst = 1;
    #1 chk("rst_abort_valid", 64'(tx_valid), 64'd0);
    @(posedge clk_sys); @(posedge clk_sys); #1;
    rst = 0;
    got.delete();
    idle(15, 1);
    chk("no_resume", 64'(got.size()), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(1, 16'h0042, 0, 0, 1); idle(12, 1);
    chk_frame("post_reset", 48'hEB9001004243);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 9) < 2, 1'($urandom),
          $urandom_range(0, 9) < 7);
    idle(150, 1);
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
